rs232_avm_responder: RTL

// Avalon-MM slave that plays the UART side of the RS232 register map (RX data 0x00, TX data 0x04,

---
 rtl/rs232_avm_responder_if.sv | 19 +
 rtl/rs232_avm_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rs232_avm_responder_if.sv
// Avalon-MM bus bundle between the RSA wrapper (master) and the RS232 responder (slave).
interface rs232_avm_responder_if;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/rs232_avm_responder.sv
// RS232 register-map stand-in: Avalon-MM slave with RX/TX byte FIFOs (RX 0x00, TX 0x04, STATUS 0x08).
// Optional sticky error register at 0x0C when AVM_RESP_ERRREG_EN is defined.
module rs232_avm_responder #(
  parameter int unsigned RX_DEPTH    = 64,
  parameter int unsigned TX_DEPTH    = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                       avm_clk,
  input  logic                       avm_rst,
  rs232_avm_responder_if.slave       avm,
  input  logic [7:0]                 rx_byte,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic [7:0]                 tx_byte,
  output logic                       tx_valid,
  input  logic                       tx_ready
);
  localparam int unsigned RXW = $clog2(RX_DEPTH);
  localparam int unsigned TXW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  addr_q, addr_d, ld_addr;
  logic        is_rd_q, is_rd_d, ld_rd;
  logic        load;
  logic        wr_q;
  logic [31:0] rdata_q, rd_val;
  logic        rd_pop_q;

  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RXW-1:0] rx_wp, rx_rp;
  logic [RXW:0]   rx_cnt;
  logic           rx_empty, rx_full, rx_push, rx_pop;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TXW-1:0] tx_wp, tx_rp;
  logic [TXW:0]   tx_cnt;
  logic           tx_empty, tx_full, tx_push, tx_pop;

  logic ack, ack_rd, ack_wr;
  logic unused_wdata;

  assign unused_wdata = ^avm.avm_writedata[31:8];

  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == (RXW+1)'(RX_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == (TXW+1)'(TX_DEPTH));

  assign rx_ready = ~rx_full;
  assign tx_valid = ~tx_empty;
  assign tx_byte  = tx_mem[tx_rp];

  assign ack    = (state_q == S_ACK);
  assign ack_rd = ack & is_rd_q;
  assign ack_wr = ack & ~is_rd_q;

  assign rx_push = rx_valid & ~rx_full;
  assign rx_pop  = ack_rd & rd_pop_q;
  assign tx_push = ack_wr & (addr_q == 5'd4) & ~tx_full;
  assign tx_pop  = tx_valid & tx_ready;

  assign avm.avm_waitrequest = wr_q;
  assign avm.avm_readdata    = rdata_q;

`ifdef AVM_RESP_ERRREG_EN
  logic tx_ovf_q, rx_udf_q;
`endif

  // With WAIT_CYCLES==0 the load happens straight from S_IDLE, so the live address is used there.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    is_rd_d = is_rd_q;
    ld_addr = addr_q;
    ld_rd   = is_rd_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (avm.avm_read | avm.avm_write) begin
          addr_d  = avm.avm_address;
          is_rd_d = avm.avm_read;
          ld_addr = avm.avm_address;
          ld_rd   = avm.avm_read;
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACK;
            load    = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!(avm.avm_read | avm.avm_write)) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = S_ACK;
          load    = 1'b1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (ld_addr)
      5'd0: rd_val[7:0] = rx_empty ? 8'h00 : rx_mem[rx_rp];
      5'd8: begin
        rd_val[7] = ~rx_empty;
        rd_val[6] = ~tx_full;
      end
`ifdef AVM_RESP_ERRREG_EN
      5'd12: rd_val[1:0] = {rx_udf_q, tx_ovf_q};
`endif
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      is_rd_q  <= 1'b0;
      wr_q     <= 1'b1;
      rdata_q  <= '0;
      rd_pop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      is_rd_q <= is_rd_d;
      wr_q    <= (state_d != S_ACK);
      if (load && ld_rd) begin
        rdata_q  <= rd_val;
        rd_pop_q <= (ld_addr == 5'd0) & ~rx_empty;
      end
    end
  end

  always_ff @(posedge avm_clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_byte;
    if (tx_push) tx_mem[tx_wp] <= avm.avm_writedata[7:0];
  end

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
    end
  end

`ifdef AVM_RESP_ERRREG_EN
  // Clear-on-read first, then same-cycle events re-set the flag so they are never lost.
  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      if (ack_rd && addr_q == 5'd12) begin
        tx_ovf_q <= 1'b0;
        rx_udf_q <= 1'b0;
      end
      if (ack_wr && addr_q == 5'd4 && tx_full)   tx_ovf_q <= 1'b1;
      if (ack_rd && addr_q == 5'd0 && !rd_pop_q) rx_udf_q <= 1'b1;
    end
  end
`endif
endmodule
